// File: rtl/core_pkg.sv
// Shared defaults and the loader state type for the instruction-memory loader.
package core_pkg;

  localparam int unsigned INSTR_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF  = 8;

  typedef enum logic [2:0] {
    StHdrLo,
    StHdrHi,
    StPayload,
    StCheck,
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/word_packer.sv
// Collects bytes MSB-first into an INSTR_W word and flags the byte that completes it.
module word_packer
  import core_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               byte_en,
  input  logic [7:0]         byte_data,
  output logic [INSTR_W-1:0] word,
  output logic               word_done
);

  localparam int unsigned Bytes = INSTR_W / 8;
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;

  logic [INSTR_W-1:0] shift_q;
  logic [CntW-1:0]    cnt_q;

  // Word including the byte on the input, valid in the cycle word_done is high.
  assign word      = (shift_q << 8) | INSTR_W'(byte_data);
  assign word_done = byte_en && (cnt_q == CntW'(Bytes - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_en) begin
      shift_q <= word;
      cnt_q   <= word_done ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a counted, XOR-checksummed byte frame into instruction memory and releases the core.
module imem_loader
  import core_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_resetn,
  output logic               done,
  output logic               error
);

  loader_state_e state_q, state_d;

  logic [7:0]         n_lo_q;
  logic [ADDR_W-1:0]  last_q;
  logic [ADDR_W-1:0]  word_q;
  logic [7:0]         csum_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] wdata_q;

  logic               accept;
  logic               pay_en;
  logic [15:0]        n_word;
  logic               n_ok;
  logic [INSTR_W-1:0] word;
  logic               word_done;

  assign accept = rx_valid && rx_ready;
  assign pay_en = accept && (state_q == StPayload);
  assign n_word = {rx_data, n_lo_q};
  assign n_ok   = (n_word != 16'd0) && (17'(n_word) <= (17'd1 << ADDR_W));

  word_packer #(
    .INSTR_W (INSTR_W)
  ) u_word_packer (
    .clk       (clk),
    .reset     (reset),
    .byte_en   (pay_en),
    .byte_data (rx_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StHdrLo;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdrLo:   if (accept) state_d = StHdrHi;
      StHdrHi:   if (accept) state_d = n_ok ? StPayload : StError;
      StPayload: if (word_done && (word_q == last_q)) state_d = StCheck;
      StCheck:   if (accept) state_d = (rx_data == csum_q) ? StDone : StError;
      StDone:    state_d = StDone;
      StError:   state_d = StError;
      default:   state_d = StError;
    endcase
  end

  always_comb begin
    rx_ready    = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    core_resetn = 1'b0;
    unique case (state_q)
      StHdrLo, StHdrHi, StPayload, StCheck: rx_ready = !reset;
      StDone: begin
        done        = 1'b1;
        core_resetn = 1'b1;
      end
      StError: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_lo_q  <= '0;
      last_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= word_done;
      if (accept && (state_q == StHdrLo)) n_lo_q <= rx_data;
      if (accept && (state_q == StHdrHi)) last_q <= ADDR_W'(n_word - 16'd1);
      if (pay_en) csum_q <= csum_q ^ rx_data;
      if (word_done) begin
        addr_q  <= word_q;
        wdata_q <= word;
        word_q  <= word_q + ADDR_W'(1);
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed vector table plus a gapped-stream sequence for imem_loader (INSTR_W=16, ADDR_W=8).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        core_resetn;
  logic        done;
  logic        error;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  imem_loader #(
    .INSTR_W (16),
    .ADDR_W  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_resetn (core_resetn),
    .done        (done),
    .error       (error)
  );

  // Inputs held for one cycle; expected outputs observed just after that cycle's edge.
  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        ready;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic        dn;
    logic        err;
    logic        crn;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic v, logic [7:0] d, logic ready, logic we,
                              logic [7:0] addr, logic [15:0] wd, logic dn, logic err,
                              logic crn);
    vec_t x;
    x.rst = rst; x.v = v; x.d = d; x.ready = ready; x.we = we; x.addr = addr; x.wd = wd;
    x.dn = dn; x.err = err; x.crn = crn;
    vecs.push_back(x);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Good frame body (after a reset row); last byte is the checksum.
  function automatic void add_frame(logic [7:0] cks, logic good);
    add(0, 1, 8'h02, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h12, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h34, 1, 1, 8'h00, 16'h1234, 0, 0, 0);
    add(0, 1, 8'hAB, 1, 0, 8'h00, 16'h1234, 0, 0, 0);
    add(0, 1, 8'hCD, 1, 1, 8'h01, 16'hABCD, 0, 0, 0);
    add(0, 1, cks,   0, 0, 8'h01, 16'hABCD, good, !good, good);
    add(0, 1, 8'h00, 0, 0, 8'h01, 16'hABCD, good, !good, good);
  endfunction

  logic [7:0]  gap_bytes [7];
  logic [15:0] got_wd [2];
  logic [7:0]  got_addr [2];
  int unsigned we_count;

  task automatic tick_mon();
    @(posedge clk);
    #1;
    check("done_and_error_exclusive", {63'd0, done && error}, 64'd0);
    if (imem_we) begin
      if (we_count < 2) begin
        got_addr[we_count] = imem_addr;
        got_wd[we_count]   = imem_wdata;
      end
      we_count++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Good load
    add(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0);
    add_frame(8'h40, 1'b1);
    // Bad checksum
    add(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0);
    add_frame(8'h41, 1'b0);
    // Zero count
    add(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 1, 0);
    // Oversize count N=257
    add(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h01, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h01, 0, 0, 8'h00, 16'h0000, 0, 1, 0);
    // Largest legal count N=256 enters payload
    add(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h01, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 0, 8'h55, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    // Reset mid-frame, then full frame from address 0
    add(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h02, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h12, 1, 0, 8'h00, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h34, 1, 1, 8'h00, 16'h1234, 0, 0, 0);
    add(0, 1, 8'hAB, 1, 0, 8'h00, 16'h1234, 0, 0, 0);
    add(1, 1, 8'hCD, 0, 0, 8'h00, 16'h0000, 0, 0, 0);
    add_frame(8'h40, 1'b1);

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      rx_valid = vecs[i].v;
      rx_data  = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rdy/we/addr/wd/dn/err/crn", i),
            {34'd0, rx_ready, imem_we, imem_addr, imem_wdata, done, error, core_resetn},
            {34'd0, vecs[i].ready, vecs[i].we, vecs[i].addr, vecs[i].wd,
             vecs[i].dn, vecs[i].err, vecs[i].crn});
    end

    // Gapped frame: 1-3 idle cycles after every byte
    gap_bytes[0] = 8'h02; gap_bytes[1] = 8'h00; gap_bytes[2] = 8'h12; gap_bytes[3] = 8'h34;
    gap_bytes[4] = 8'hAB; gap_bytes[5] = 8'hCD; gap_bytes[6] = 8'h40;
    we_count = 0;
    got_addr[0] = '0; got_addr[1] = '0; got_wd[0] = '0; got_wd[1] = '0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int b = 0; b < 7; b++) begin
      rx_valid = 1'b1;
      rx_data  = gap_bytes[b];
      tick_mon();
      rx_valid = 1'b0;
      rx_data  = 8'hFF;
      for (int g = 0, n = 1 + ((b * 7 + 3) % 3); g < n; g++) tick_mon();
    end
    for (int g = 0; g < 3; g++) tick_mon();
    check("gap_we_count", 64'(we_count), 64'd2);
    check("gap_write0", {40'd0, got_addr[0], got_wd[0]}, {40'd0, 8'h00, 16'h1234});
    check("gap_write1", {40'd0, got_addr[1], got_wd[1]}, {40'd0, 8'h01, 16'hABCD});
    check("gap_done", {61'd0, done, core_resetn, rx_ready}, {61'd0, 1'b1, 1'b1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter INSTR_W, default 16: instruction width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 8: instruction memory address width; capacity is 2^ADDR_W words.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on the rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 rx_valid  input  1  byte-stream valid.
REQ-006 rx_data  input  8  byte-stream data.
REQ-007 rx_ready  output  1  loader can accept a byte.
REQ-008 imem_we  output  1  instruction memory write strobe.
REQ-009 imem_addr  output  ADDR_W  write address.
REQ-010 imem_wdata  output  INSTR_W  write data.
REQ-011 core_resetn  output  1  active-low reset to the core; high only after a good load.
REQ-012 done  output  1  load completed with a good checksum.
REQ-013 error  output  1  load rejected.

Function
REQ-014 A byte SHALL be accepted on any cycle with rx_valid=1 and rx_ready=1; no other cycle consumes a byte.
REQ-015 Frame format: count low byte, count high byte (N, 16 bits), N x INSTR_W/8 payload bytes, one checksum byte.
REQ-016 States: HDR_LO, HDR_HI, PAYLOAD, CHECK, DONE, ERROR; rx_ready=1 in HDR_LO, HDR_HI, PAYLOAD and CHECK, and 0 in DONE and ERROR.
REQ-017 HDR_LO -> HDR_HI on an accepted byte.
REQ-018 HDR_HI -> PAYLOAD on an accepted byte if 1 <= N <= 2^ADDR_W; otherwise -> ERROR.
REQ-019 Each payload word SHALL be assembled MSB-first: the first byte of a word is bits [INSTR_W-1:INSTR_W-8].
REQ-020 imem_we SHALL pulse for exactly one cycle, the cycle after the last byte of a word is accepted, with imem_addr = word index (0..N-1) and imem_wdata = the assembled word.
REQ-021 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.
REQ-022 PAYLOAD -> CHECK after byte N x INSTR_W/8 is accepted.
REQ-023 The running checksum SHALL be the XOR of all payload bytes; header bytes are excluded.
REQ-024 In CHECK, an accepted byte equal to the checksum SHALL give -> DONE; any other value SHALL give -> ERROR.
REQ-025 DONE: done=1, core_resetn=1, from the cycle after the checksum byte is accepted.
REQ-026 ERROR: error=1, core_resetn=0.
REQ-027 DONE and ERROR SHALL be left only by reset.
REQ-028 Idle cycles (rx_valid=0) at any point SHALL not change state, counters or checksum.
REQ-029 done and error SHALL never be 1 together.

Reset
REQ-030 While reset=1, on the next edge:
- state SHALL go to HDR_LO;
- imem_we, done, error, core_resetn, imem_addr and imem_wdata SHALL be 0;
- the byte counter, word counter and checksum SHALL be cleared.
REQ-031 rx_ready SHALL be 0 while reset=1.
REQ-032 Reset mid-frame SHALL abandon the frame; words already written are not erased, and the next frame loads from address 0.
REQ-033 While reset=1, no byte SHALL be accepted and no imem_we SHALL be issued.

Structure
REQ-034 Shared package core_pkg SHALL hold INSTR_W and ADDR_W defaults and the loader state enum type.
REQ-035 Sub-module word_packer SHALL hold the byte shift register and the byte-in-word counter, and SHALL flag word-complete; the FSM, checksum and word counter stay in imem_loader.

Verification (INSTR_W=16, ADDR_W=8)
REQ-036 Good load: bytes 02 00 12 34 AB CD 40, each with rx_valid=1 on consecutive cycles.
- Required response: writes [0]=0x1234 and [1]=0xABCD; then done=1, core_resetn=1, rx_ready=0.
REQ-037 Bad checksum: same frame ending in 41.
- Required response: the same two writes occur; then error=1, core_resetn=0, done=0.
REQ-038 Zero count: bytes 00 00.
- Required response: error=1 the cycle after the second byte; no imem_we.
REQ-039 Oversize count: bytes 01 01 (N=257).
- Required response: ERROR and no imem_we.
REQ-040 Gaps: REQ-036 frame with 1-3 idle cycles between every byte.
- Required response: identical writes, exactly 2 imem_we pulses, done=1.
REQ-041 Reset mid-frame: reset for one cycle after 02 00 12 34 AB, then the full REQ-036 frame.
- Required response: all outputs 0 after the reset edge; final writes [0]=0x1234 and [1]=0xABCD; done=1.
